mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//   Multicycle control FSM for the 32-bit MIPS CPU datapath (PC, IR, A, B, ALUOut, MDR, Regs, Memory).
//   Sequences each instruction FETCH->DECODE->EXEC->MEM->WB and drives every datapath load enable and mux select.
//   Adds a request/ready handshake so the shared instruction/data memory may stall.
//   Adds a stall watchdog and a retired-instruction counter.
// PARAMETERS
//   OPC_RTYPE    6'b000000  R-type opcode
//   OPC_LW       6'b100011  load word
//   OPC_SW       6'b101011  store word
//   OPC_BEQ      6'b000100  branch if equal
//   OPC_J        6'b000010  jump
//   FUNCT_ADD    6'd32      R-type add funct; every other funct is pass-A
//   STALL_LIMIT  16         consecutive mem wait cycles before abort; 0 = watchdog disabled
// PORTS
//   clock        in   1   rising-edge clock
//   reset        in   1   synchronous, active-high
//   opcode       in   6   IR[31:26]; valid from DECODE until retire
//   funct        in   6   IR[5:0]
//   zero         in   1   A==B compare result
//   mem_ready    in   1   memory completes request this cycle
//   mem_req      out  1   memory access request
//   mem_we       out  1   1 = write B to Memory[ALUOut>>2]
//   iord         out  1   memory address: 0 = PC, 1 = ALUOut
//   ir_write     out  1   load IR from memory read data
//   ab_load      out  1   load A<=Regs[rs], B<=Regs[rt]
//   aluout_load  out  1   load ALUOut from ALU result
//   alu_sel      out  2   0: PC+(signext<<2); 1: A+signext; 2: A+B; 3: pass A
//   pc_en        out  1   load PC from pc_src
//   pc_src       out  2   0: PC+4; 1: ALUOut; 2: {PC[31:28],IR[25:0],2'b00}
//   mdr_load     out  1   load MDR from memory read data
//   reg_write    out  1   write register file
//   reg_dst      out  1   destination register: 0 = rt (IR[20:16]), 1 = rd (IR[15:11])
//   mem_to_reg   out  1   write data: 0 = ALUOut, 1 = MDR
//   instr_done   out  1   1-cycle pulse when an instruction retires
//   illegal      out  1   1-cycle pulse on an undefined opcode or a bad state
//   timeout      out  1   1-cycle pulse on a watchdog abort
//   instr_count  out  32  retired-instruction count; wraps 2^32-1 -> 0
//   state        out  3   current state (debug)
// BEHAVIOUR
//   - State encoding: FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
//     Codes 0, 6 and 7 are illegal: pulse illegal and go to FETCH.
//   - Reset: state=FETCH, instr_count=0, wait counter=0. All outputs are 0 while reset is high.
//   - Outputs are combinational from state, opcode, funct, zero and mem_ready. Unlisted strobes are 0.
//   - FETCH: mem_req=1, iord=0.
//     If mem_ready: ir_write=1, pc_en=1, pc_src=0, go to DECODE. Otherwise stay; nothing is written.
//   - DECODE: ab_load=1, aluout_load=1, alu_sel=0 (branch target), go to EXEC.
//   - EXEC, by opcode:
//     - LW/SW: aluout_load=1, alu_sel=1, go to MEM.
//     - R-type: aluout_load=1, alu_sel = (funct==FUNCT_ADD) ? 2 : 3, go to MEM.
//     - BEQ: pc_en=zero, pc_src=1, instr_done=1, go to FETCH.
//     - J: pc_en=1, pc_src=2, instr_done=1, go to FETCH.
//     - Other opcode: illegal=1, go to FETCH; the instruction does not count.
//   - MEM, by opcode:
//     - R-type: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, go to FETCH.
//     - LW: mem_req=1, iord=1. If mem_ready: mdr_load=1, go to WB. Otherwise stay.
//     - SW: mem_req=1, mem_we=1, iord=1. If mem_ready: instr_done=1, go to FETCH. Otherwise stay.
//   - WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, go to FETCH.
//   - Handshake: while waiting, mem_req, iord and mem_we stay stable until mem_ready is sampled high.
//     mem_ready is ignored outside FETCH and LW/SW MEM.
//   - Latency with mem_ready tied to 1: R-type 4 cycles, SW 4, LW 5, BEQ/J 3, illegal opcode 3.
//   - Watchdog:
//     - The wait counter increments on each cycle with mem_req=1 and mem_ready=0. It clears on mem_ready or a state change.
//     - When the counter reaches STALL_LIMIT: pulse timeout, drop mem_req, go to FETCH.
//       PC, IR, MDR, Regs and Memory are not written. A fetch abort refetches the same PC.
//   - instr_count increments on each cycle where instr_done=1.
//   - Reset during a stall: the request drops in the reset cycle. No mem_we or reg_write is issued. Next state is FETCH.
// TESTING
//   - add r3,r1,r2 (funct 32), ready=1 -> states 1,2,3,4,1; alu_sel 0 then 2; reg_write with reg_dst=1 in cycle 4; instr_count=1.
//   - lw, with mem_ready low for 3 cycles in MEM -> state holds at 4 with mem_req=1 and iord=1;
//     mdr_load on the ready cycle; WB reg_write with mem_to_reg=1; total 8 cycles.
//   - sw -> mem_we=1 only in MEM; no reg_write ever; retires in 4 cycles.
//   - beq with zero=1 -> pc_en=1, pc_src=1 in EXEC. With zero=0 -> pc_en=0. Both retire in 3 cycles.
//   - opcode 6'h3F -> illegal pulse in EXEC, back to FETCH, instr_count unchanged.
//     With STALL_LIMIT=4 and ready held low in FETCH -> timeout after 4 wait cycles, no ir_write.
//   - reset asserted mid-LW stall -> all outputs 0 during reset; state=1 and instr_count=0 afterwards.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// stallable memory handshake, a stall watchdog and a retired-instruction counter.
module mips_mc_control #(
  parameter logic [5:0]  OPC_RTYPE   = 6'b000000,
  parameter logic [5:0]  OPC_LW      = 6'b100011,
  parameter logic [5:0]  OPC_SW      = 6'b101011,
  parameter logic [5:0]  OPC_BEQ     = 6'b000100,
  parameter logic [5:0]  OPC_J       = 6'b000010,
  parameter logic [5:0]  FUNCT_ADD   = 6'd32,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        ab_load,
  output logic        aluout_load,
  output logic [1:0]  alu_sel,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        mdr_load,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instr_count,
  output logic [2:0]  state
);

  localparam int unsigned WW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   count_q;
  logic          abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      count_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done)
        count_q <= count_q + 32'd1;
      if (!mem_req || mem_ready)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    alu_sel     = 2'd0;
    pc_en       = 1'b0;
    pc_src      = 2'd0;
    mdr_load    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    timeout     = 1'b0;
    abort       = 1'b0;
    state_d     = state_q;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        ab_load     = 1'b1;
        aluout_load = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OPC_LW, OPC_SW: begin
            aluout_load = 1'b1;
            alu_sel     = 2'd1;
            state_d     = MEM;
          end
          OPC_RTYPE: begin
            aluout_load = 1'b1;
            alu_sel     = (funct == FUNCT_ADD) ? 2'd2 : 2'd3;
            state_d     = MEM;
          end
          OPC_BEQ: begin
            pc_en      = zero;
            pc_src     = 2'd1;
            instr_done = 1'b1;
          end
          OPC_J: begin
            pc_en      = 1'b1;
            pc_src     = 2'd2;
            instr_done = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        if (opcode == OPC_RTYPE) begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (opcode == OPC_LW) begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            mdr_load = 1'b1;
            state_d  = WB;
          end
        end else if (opcode == OPC_SW) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        illegal = 1'b1;
        state_d = FETCH;
      end
    endcase

    // Abort overrides every write strobe so nothing architectural changes; a
    // fetch abort leaves PC untouched, so the same address is refetched.
    abort = (STALL_LIMIT != 0) && mem_req && (wait_cnt == WW'(STALL_LIMIT));
    if (abort) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      mdr_load   = 1'b0;
      instr_done = 1'b0;
      timeout    = 1'b1;
      state_d    = FETCH;
    end

    if (reset) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      ab_load     = 1'b0;
      aluout_load = 1'b0;
      alu_sel     = 2'd0;
      pc_en       = 1'b0;
      pc_src      = 2'd0;
      mdr_load    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      timeout     = 1'b0;
      state_d     = FETCH;
    end
  end

  assign instr_count = reset ? 32'd0 : count_q;
  assign state       = reset ? 3'd0  : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle state and strobe vectors for
// each instruction class, stalls, watchdog aborts and reset mid-stall.
module tb_mips_mc_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, ab_load, aluout_load;
  logic [1:0]  alu_sel, pc_src;
  logic        pc_en, mdr_load, reg_write, reg_dst, mem_to_reg;
  logic        instr_done, illegal, timeout;
  logic [31:0] instr_count;
  logic [2:0]  state;
  logic [17:0] ctl;

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;

  localparam logic [17:0] REQ  = 18'h20000, WE   = 18'h10000, IORD = 18'h08000;
  localparam logic [17:0] IRW  = 18'h04000, ABL  = 18'h02000, AOL  = 18'h01000;
  localparam logic [17:0] ALU1 = 18'h00400, ALU2 = 18'h00800, ALU3 = 18'h00C00;
  localparam logic [17:0] PCEN = 18'h00200, PCS1 = 18'h00080, PCS2 = 18'h00100;
  localparam logic [17:0] MDR  = 18'h00040, RW   = 18'h00020, RDST = 18'h00010;
  localparam logic [17:0] M2R  = 18'h00008, DONE = 18'h00004, ILL  = 18'h00002;
  localparam logic [17:0] TMO  = 18'h00001, NONE = 18'h00000;
  localparam logic [17:0] FOK  = REQ | IRW | PCEN;
  localparam logic [17:0] DEC  = ABL | AOL;
  localparam logic [2:0]  SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SB = 3'd5;

  assign ctl = {mem_req, mem_we, iord, ir_write, ab_load, aluout_load, alu_sel,
                pc_en, pc_src, mdr_load, reg_write, reg_dst, mem_to_reg,
                instr_done, illegal, timeout};

  mips_mc_control #(.STALL_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .ab_load(ab_load), .aluout_load(aluout_load),
    .alu_sel(alu_sel), .pc_en(pc_en), .pc_src(pc_src), .mdr_load(mdr_load),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal(illegal), .timeout(timeout),
    .instr_count(instr_count), .state(state)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      vectors++;
      if (ctl !== NONE || state !== 3'd0 || instr_count !== 32'd0) begin
        $display("FAIL reset c%0d: ctl=%h state=%0d cnt=%0d, expected ctl=0 state=0 cnt=0", i, ctl, state, instr_count);
        errors++;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (ctl !== REQ || state !== SF || instr_count !== 32'd0) begin
      $display("FAIL reset_release: ctl=%h state=%0d cnt=%0d, expected ctl=%h state=1 cnt=0", ctl, state, instr_count, REQ);
      errors++;
    end
  endtask

  task automatic test_rtype(input logic [5:0] f);
    logic [17:0] ec[4];
    logic [2:0]  es[4];
    ec = '{FOK, DEC, AOL | ((f == 6'd32) ? ALU2 : ALU3), RW | RDST | DONE};
    es = '{SF, SD, SE, SM};
    opcode = 6'h00;
    funct = f;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL rtype f=%0d c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", f, i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL rtype_retire: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  task automatic test_lw_stall();
    logic [17:0] ec[8];
    logic [2:0]  es[8];
    logic        rdy[8];
    ec  = '{FOK, DEC, AOL | ALU1, REQ | IORD, REQ | IORD, REQ | IORD, REQ | IORD | MDR, RW | M2R | DONE};
    es  = '{SF, SD, SE, SM, SM, SM, SM, SB};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'h23;
    funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      mem_ready = rdy[i];
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL lw_stall c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL lw_retire: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  task automatic test_sw();
    logic [17:0] ec[4];
    logic [2:0]  es[4];
    ec = '{FOK, DEC, AOL | ALU1, REQ | WE | IORD | DONE};
    es = '{SF, SD, SE, SM};
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL sw c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL sw_retire: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  // Covers BEQ (either zero value), J and an undefined opcode: all end in EXEC.
  task automatic test_three_cycle(input logic [5:0] op, input logic z);
    logic [17:0] ec[3];
    logic [2:0]  es[3];
    logic [17:0] ex;
    if (op == 6'h04)      ex = PCS1 | DONE | (z ? PCEN : NONE);
    else if (op == 6'h02) ex = PCEN | PCS2 | DONE;
    else                  ex = ILL;
    ec = '{FOK, DEC, ex};
    es = '{SF, SD, SE};
    opcode = op;
    zero = z;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL op%h z%0d c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", op, z, i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    if (ex != ILL) exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL op%h_retire: state=%0d cnt=%0d, expected state=1 cnt=%0d", op, state, instr_count, exp_count);
      errors++;
    end
    zero = 1'b0;
  endtask

  task automatic test_fetch_timeout();
    logic [17:0] ec[8];
    logic [2:0]  es[8];
    logic        rdy[8];
    ec  = '{REQ, REQ, REQ, REQ, TMO, FOK, DEC, PCEN | PCS2 | DONE};
    es  = '{SF, SF, SF, SF, SF, SF, SD, SE};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'h02;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      mem_ready = rdy[i];
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL fetch_timeout c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL fetch_timeout_end: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  task automatic test_mem_timeout();
    logic [17:0] ec[8];
    logic [2:0]  es[8];
    logic        rdy[8];
    ec  = '{FOK, DEC, AOL | ALU1, REQ | WE | IORD, REQ | WE | IORD, REQ | WE | IORD, REQ | WE | IORD, TMO};
    es  = '{SF, SD, SE, SM, SM, SM, SM, SM};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    opcode = 6'h2B;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      mem_ready = rdy[i];
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL mem_timeout c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL mem_timeout_end: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [17:0] ec[5];
    logic [2:0]  es[5];
    logic        rdy[5];
    ec  = '{FOK, DEC, AOL | ALU1, REQ | IORD, REQ | IORD};
    es  = '{SF, SD, SE, SM, SM};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'h23;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      mem_ready = rdy[i];
      #1;
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        $display("FAIL reset_lw c%0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, es[i], ec[i]);
        errors++;
      end
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++;
    if (ctl !== NONE || state !== 3'd0 || instr_count !== 32'd0) begin
      $display("FAIL reset_lw_during: ctl=%h state=%0d cnt=%0d, expected ctl=0 state=0 cnt=0", ctl, state, instr_count);
      errors++;
    end
    exp_count = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h02;
    #1;
    vectors++;
    if (ctl !== FOK || state !== SF || instr_count !== 32'd0) begin
      $display("FAIL reset_lw_after: ctl=%h state=%0d cnt=%0d, expected ctl=%h state=1 cnt=0", ctl, state, instr_count, FOK);
      errors++;
    end
    @(negedge clock); #1;
    @(negedge clock); #1;
    vectors++;
    if (ctl !== (PCEN | PCS2 | DONE) || state !== SE) begin
      $display("FAIL reset_lw_j: ctl=%h state=%0d, expected ctl=%h state=3", ctl, state, PCEN | PCS2 | DONE);
      errors++;
    end
    exp_count++;
    @(posedge clock); #1;
    vectors++;
    if (state !== SF || instr_count !== exp_count) begin
      $display("FAIL reset_lw_end: state=%0d cnt=%0d, expected state=1 cnt=%0d", state, instr_count, exp_count);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype(6'd32);
    test_rtype(6'd0);
    test_lw_stall();
    test_sw();
    test_three_cycle(6'h04, 1'b1);
    test_three_cycle(6'h04, 1'b0);
    test_three_cycle(6'h02, 1'b0);
    test_three_cycle(6'h3F, 1'b0);
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_lw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: run exceeded 200000 time units");
    $fatal(1);
  end

endmodule
